matrix_add_ctrl: RTL

- Row-serial sequencer for element-wise matrix addition C = A + B over H x W operands held in external row-addressed memories.
- On start, issues H row reads, adds the returned A/B rows lane-by-lane with one W-lane adder row, and writes C rows under a ready/valid handshake.
- Sits between the RBM weight/gradient buffers and the result buffer. It replaces full-matrix combinational addition when H x W ports are too wide to route.

---
 rtl/matrix_add_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/matrix_add_ctrl.sv
// Row-serial C = A + B sequencer: reads A/B rows from external memories, adds
// them lane-wise and streams C rows through a 2-entry ready/valid output FIFO.
module matrix_add_ctrl #(
  parameter int bitlength = 8,
  parameter int H         = 3,
  parameter int W         = 4,
  parameter int AW        = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_en,
  output logic [AW-1:0]          rd_row,
  input  logic [W*bitlength-1:0] a_row,
  input  logic [W*bitlength-1:0] b_row,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic [AW-1:0]          wr_row,
  output logic [W*bitlength-1:0] c_row
);

  localparam int RW = W * bitlength;
  localparam int CW = $clog2(H + 1);
  localparam logic [CW-1:0] H_C    = CW'(H);
  localparam logic [CW-1:0] LAST_C = CW'(H - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  function automatic logic [RW-1:0] add_row(input logic [RW-1:0] a,
                                            input logic [RW-1:0] b);
    logic [RW-1:0] s;
    s = '0;
    for (int j = 0; j < W; j++)
      s[j*bitlength +: bitlength] = a[j*bitlength +: bitlength] + b[j*bitlength +: bitlength];
    return s;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic            inflight_q;
  logic [AW-1:0]   rd_row_q;

  logic [AW-1:0]   fifo_row_q [2];
  logic [RW-1:0]   fifo_dat_q [2];
  logic            wp_q, rp_q;
  logic [1:0]      fifo_cnt_q;

  logic            push, pop;
  logic [1:0]      occ;

  assign wr_valid = (fifo_cnt_q != 2'd0);
  assign wr_row   = fifo_row_q[rp_q];
  assign c_row    = fifo_dat_q[rp_q];
  assign pop      = wr_valid & wr_ready;
  assign push     = inflight_q;

  // A slot being popped this cycle counts as free, which keeps reads
  // back-to-back when the sink never stalls.
  assign occ    = fifo_cnt_q - 2'(pop) + 2'(inflight_q);
  assign rd_row = rd_en ? AW'(rd_cnt_q) : rd_row_q;

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    rd_en    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if ((rd_cnt_q < H_C) && (occ < 2'd2)) begin
          rd_en    = 1'b1;
          rd_cnt_d = rd_cnt_q + CW'(1);
        end
        if (pop) begin
          wr_cnt_d = wr_cnt_q + CW'(1);
          if (wr_cnt_q == LAST_C) state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      inflight_q <= 1'b0;
      rd_row_q   <= '0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      inflight_q <= rd_en;
      if (rd_en) rd_row_q <= rd_row;
    end
  end

  // Capture stage: memory data for the row read last cycle is summed and queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_row_q[i] <= '0;
        fifo_dat_q[i] <= '0;
      end
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (push) begin
        fifo_row_q[wp_q] <= rd_row_q;
        fifo_dat_q[wp_q] <= add_row(a_row, b_row);
        wp_q             <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      fifo_cnt_q <= fifo_cnt_q + 2'(push) - 2'(pop);
    end
  end

endmodule
